// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control sequencer and the datapath muxes:
// state codes, mux select codes, instruction class codes and the Moore control bundle.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_BOOT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMREAD  = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWRITE = 4'd6,
    ST_EXECR    = 4'd7,
    ST_EXECI    = 4'd8,
    ST_ALUWB    = 4'd9,
    ST_BRANCH   = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BRANCH  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int FUNCT_IMM_BIT = 5;
  localparam int FUNCT_L_BIT   = 0;

  // Outputs that depend only on the current state.
  typedef struct packed {
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Purely combinational state-to-control map for the Moore outputs of the sequencer.
module mc_output_decode
  import mc_control_fsm_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
      end
      // PC+8 lands on the result bus so R15 reads correctly during execute.
      ST_DECODE: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      ST_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_w      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEMWRITE: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.mem_w      = 1'b1;
      end
      ST_EXECR: begin
        ctrl_o.alu_src_b = SRCB_WDATA;
        ctrl_o.alu_op    = 1'b1;
      end
      ST_EXECI: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = 1'b1;
      end
      ST_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_w      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.branch     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: state register, next-state logic and the few
// outputs that also depend on mem_ready / op in the current cycle.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       next_pc,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   unused_funct;

  assign unused_funct = ^funct[4:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_MEM:    state_d = ST_MEMADR;
          OP_DP:     state_d = funct[FUNCT_IMM_BIT] ? ST_EXECI : ST_EXECR;
          OP_BRANCH: state_d = ST_BRANCH;
          default:   state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:   state_d = funct[FUNCT_L_BIT] ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  state_d = mem_ready ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: state_d = mem_ready ? ST_FETCH : ST_MEMWRITE;
      ST_EXECR:    state_d = ST_ALUWB;
      ST_EXECI:    state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      default:     state_d = ST_BOOT;
    endcase
  end

  mc_output_decode u_output_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // A store completes only on the cycle the memory accepts it.
  always_comb begin
    adr_src    = ctrl.adr_src;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    result_src = ctrl.result_src;
    alu_op     = ctrl.alu_op;
    reg_w      = ctrl.reg_w;
    mem_w      = ctrl.mem_w;
    branch     = ctrl.branch;
    instr_done = ctrl.instr_done | ((state_q == ST_MEMWRITE) & mem_ready);
    ir_write   = (state_q == ST_FETCH) & mem_ready;
    next_pc    = (state_q == ST_FETCH) & mem_ready;
    illegal_op = (state_q == ST_DECODE) & (op == OP_ILLEGAL);
    state_o    = state_q;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a per-cycle reference model pushes expected control
// vectors into a queue, and a negedge monitor pops and compares them.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       ir_write, next_pc, adr_src, alu_src_a, alu_op;
  logic       reg_w, mem_w, branch, instr_done, illegal_op;
  logic [1:0] alu_src_b, result_src;
  logic [3:0] state_o;

  logic [17:0] exp_q[$];
  logic [17:0] act_v;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .next_pc    (next_pc),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .branch     (branch),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  assign act_v = {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
                  alu_op, reg_w, mem_w, branch, instr_done, illegal_op, state_o};

  // Field order: irw npc adr srca srcb res aluop regw memw br done ill state
  function automatic logic [17:0] mk(input logic [3:0] st, input bit irw, input bit npc,
                                     input bit adr, input bit srca, input logic [1:0] srcb,
                                     input logic [1:0] res, input bit aluop, input bit regw,
                                     input bit memw, input bit br, input bit done, input bit ill);
    return {irw, npc, adr, srca, srcb, res, aluop, regw, memw, br, done, ill, st};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor_empty actual=%b required=none at %0t", act_v, $time);
      end else begin
        check("cycle", act_v, exp_q.pop_front());
      end
    end
  end

  // One cycle: drive mem_ready, queue the expected vector, advance past the edge.
  task automatic step(input bit mr, input logic [17:0] exp);
    mem_ready = mr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input int sf,
                           input int sm, input bit abort);
    op = o;
    funct = f;
    for (int i = 0; i < sf; i++) step(1'b0, mk(4'd1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step(1'b1, mk(4'd1, 1, 1, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    step(1'($urandom_range(0, 1)), mk(4'd2, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, o == 2'b11));
    case (o)
      2'b10: step(1'($urandom_range(0, 1)), mk(4'd10, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 1, 1, 0));
      2'b00: begin
        if (f[5]) step(1'($urandom_range(0, 1)), mk(4'd8, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0));
        else      step(1'($urandom_range(0, 1)), mk(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
        step(1'($urandom_range(0, 1)), mk(4'd9, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0));
      end
      2'b01: begin
        step(1'($urandom_range(0, 1)), mk(4'd3, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        if (f[0]) begin
          for (int i = 0; i < sm; i++) step(1'b0, mk(4'd4, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
          step(1'b1, mk(4'd4, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
          step(1'($urandom_range(0, 1)), mk(4'd5, 0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 1, 0));
        end else begin
          for (int i = 0; i < sm; i++) step(1'b0, mk(4'd6, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0));
          if (abort) begin
            // Reset lands mid-stall: outputs must collapse before any clock edge.
            mon_en = 1'b0;
            mem_ready = 1'b0;
            rst_n = 1'b0;
            #1;
            check("reset_async_mem_w", {17'd0, mem_w}, 18'd0);
            check("reset_async_vec", act_v, 18'd0);
            @(posedge clk);
            #1;
            check("reset_held_vec", act_v, 18'd0);
            rst_n = 1'b1;
            mon_en = 1'b1;
            step(1'($urandom_range(0, 1)), 18'd0);
          end else begin
            step(1'b1, mk(4'd6, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0));
          end
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("reset_vec", act_v, 18'd0);
    mon_en = 1'b1;
    step(1'b1, 18'd0);
    rst_n = 1'b1;
    step(1'b1, 18'd0);

    run_instr(2'b00, 6'b101000, 0, 0, 1'b0);
    run_instr(2'b01, 6'b011001, 0, 2, 1'b0);
    run_instr(2'b01, 6'b011000, 0, 3, 1'b0);
    run_instr(2'b10, 6'b000000, 0, 0, 1'b0);
    run_instr(2'b11, 6'b111111, 0, 0, 1'b0);
    run_instr(2'b00, 6'b000100, 2, 0, 1'b0);
    run_instr(2'b01, 6'b011000, 1, 2, 1'b1);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] o;
      logic [5:0] f;
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom_range(0, 63));
      run_instr(o, f, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
